front_panel_loader: RTL and testbench

Front-panel controller upstream of the CPU control unit. It debounces operator buttons and deposits switch-entered words into program memory using the same CS/WE/Ac write discipline as PUT. It then sequences CPU start-up by pulsing `turn_ON`, holding `start_computer`, and driving `status` (run/halt/step), which gates instruction fetch.

---
 rtl/front_panel_loader.sv | 175 +++++++++++++++++
 tb/tb_front_panel_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/front_panel_loader.sv
// Front-panel loader: debounced buttons, switch deposit into program memory, CPU start/halt sequencing.
// Optional single-step state enabled by defining FRONT_PANEL_STEP_EN.
module front_panel_loader #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int DEB_CYC   = 16,
   parameter int START_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] switches,
   input  logic              btn_addr,
   input  logic              btn_dep,
   input  logic              btn_run,
   input  logic              btn_halt,
   input  logic              btn_step,
   input  logic              start_FETCH,
   output logic [ADDR_W-1:0] panel_addr,
   output logic [DATA_W-1:0] panel_data,
   output logic              panel_bus,
   output logic              CS,
   output logic              WE,
   output logic              Ac,
   output logic              turn_ON,
   output logic              start_computer,
   output logic              status,
   output logic              busy,
   output logic [3:0]        dbg_state_o
);

   localparam int NB = 5;
   localparam int DW = $clog2(DEB_CYC) + 1;
   localparam int TW = 16;

   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] SETUP = 4'd1;
   localparam logic [3:0] WRITE = 4'd2;
   localparam logic [3:0] HOLD  = 4'd3;
   localparam logic [3:0] DONE  = 4'd4;
   localparam logic [3:0] CLR   = 4'd5;
   localparam logic [3:0] START = 4'd6;
   localparam logic [3:0] RUN   = 4'd7;
   localparam logic [3:0] STEP  = 4'd8;

   logic          step_raw;
   logic [NB-1:0] raw;
   logic [NB-1:0] s1_q, s2_q, lvl_q, evt_q;
   logic [DW-1:0] cnt_q [NB];

`ifdef FRONT_PANEL_STEP_EN
   assign step_raw = btn_step;
`else
   logic unused_step_ok;
   assign step_raw       = 1'b0;
   assign unused_step_ok = &{1'b0, btn_step, start_FETCH};
`endif

   // bit order: 0 addr, 1 dep, 2 run, 3 halt, 4 step
   assign raw = {step_raw, btn_halt, btn_run, btn_dep, btn_addr};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q  <= '0;
         s2_q  <= '0;
         lvl_q <= '0;
         evt_q <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         for (int i = 0; i < NB; i++) begin
            evt_q[i] <= 1'b0;
            if (s2_q[i] == lvl_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DW'(DEB_CYC - 1)) begin
               // DEB_CYC-th consecutive differing sample: accept the new level
               cnt_q[i] <= '0;
               lvl_q[i] <= s2_q[i];
               evt_q[i] <= s2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   logic ev_halt, ev_step, ev_run, ev_addr, ev_dep;
   assign ev_halt = evt_q[3];
   assign ev_step = evt_q[4] & ~evt_q[3];
   assign ev_run  = evt_q[2] & ~|evt_q[4:3];
   assign ev_addr = evt_q[0] & ~|evt_q[4:2];
   assign ev_dep  = evt_q[1] & ~|{evt_q[4:2], evt_q[0]};

   logic [3:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              ton_q, ton_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      tmr_d   = '0;
      case (state_q)
         IDLE: begin
            if (ev_step) begin
`ifdef FRONT_PANEL_STEP_EN
               state_d = STEP;
`endif
            end else if (ev_run) begin
               state_d = CLR;
            end else if (ev_addr) begin
               addr_d = switches[ADDR_W-1:0];
            end else if (ev_dep) begin
               data_d  = switches;
               state_d = SETUP;
            end
         end
         SETUP: state_d = WRITE;
         WRITE: begin
            if (tmr_q == TW'(1)) state_d = HOLD;
            else tmr_d = tmr_q + 1'b1;
         end
         HOLD: state_d = DONE;
         DONE: begin
            addr_d  = addr_q + 1'b1;
            state_d = IDLE;
         end
         CLR: state_d = START;
         START: begin
            if (tmr_q == TW'(START_CYC - 1)) state_d = RUN;
            else tmr_d = tmr_q + 1'b1;
         end
         RUN: if (ev_halt) state_d = IDLE;
`ifdef FRONT_PANEL_STEP_EN
         STEP: if (ev_halt || start_FETCH) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
      ton_d = (state_d == CLR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         tmr_q   <= '0;
         ton_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tmr_q   <= tmr_d;
         ton_q   <= ton_d;
      end
   end

   logic drive;
   assign drive          = (state_q == SETUP) || (state_q == WRITE) || (state_q == HOLD);
   assign panel_addr     = addr_q;
   assign panel_data     = data_q;
   assign panel_bus      = drive;
   assign CS             = ~drive;
   assign WE             = ~(state_q == WRITE);
   assign Ac             = drive;
   assign turn_ON        = ton_q;
   assign start_computer = (state_q == START);
   // halt during a step drops the fetch gate in the same cycle
   assign status         = (state_q == RUN) || ((state_q == STEP) && !ev_halt);
   assign busy           = drive || (state_q == DONE) || (state_q == CLR) || (state_q == START);
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_front_panel_loader.sv
// Directed bench for front_panel_loader with DEB_CYC=4; step section depends on FRONT_PANEL_STEP_EN.
module tb_front_panel_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] switches;
   logic       btn_addr, btn_dep, btn_run, btn_halt, btn_step, start_FETCH;
   logic [3:0] panel_addr;
   logic [7:0] panel_data;
   logic       panel_bus, CS, WE, Ac, turn_ON, start_computer, status, busy;
   logic [3:0] dbg_state;

   always #5 clk = ~clk;

   front_panel_loader #(
      .ADDR_W(4), .DATA_W(8), .DEB_CYC(4), .START_CYC(2)
   ) dut (
      .clk(clk), .reset(reset), .switches(switches),
      .btn_addr(btn_addr), .btn_dep(btn_dep), .btn_run(btn_run),
      .btn_halt(btn_halt), .btn_step(btn_step), .start_FETCH(start_FETCH),
      .panel_addr(panel_addr), .panel_data(panel_data), .panel_bus(panel_bus),
      .CS(CS), .WE(WE), .Ac(Ac), .turn_ON(turn_ON),
      .start_computer(start_computer), .status(status), .busy(busy),
      .dbg_state_o(dbg_state)
   );

   // {panel_bus, CS, WE, Ac, turn_ON, start_computer, status, busy}
   logic [7:0] ctl;
   assign ctl = {panel_bus, CS, WE, Ac, turn_ON, start_computer, status, busy};

`ifdef FRONT_PANEL_STEP_EN
   localparam int STEP_EXP = 4;
`else
   localparam int STEP_EXP = 0;
`endif

   int checks = 0;
   int errors = 0;
   int cs_lo, we_lo, stat_hi;

   logic [7:0] dep_tab [6] = '{8'b1011_0001, 8'b1001_0001, 8'b1001_0001,
                               8'b1011_0001, 8'b0110_0001, 8'b0110_0000};
   logic [7:0] run_tab [4] = '{8'b0110_1001, 8'b0110_0101, 8'b0110_0101, 8'b0110_0010};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; switches = 8'h00; start_FETCH = 1'b0;
      btn_addr = 1'b0; btn_dep = 1'b0; btn_run = 1'b0; btn_halt = 1'b0; btn_step = 1'b0;
      cyc(2);
      chk("reset_ctl", ctl, 8'b0110_1000);
      chk("reset_addr", panel_addr, 4'h0);
      chk("reset_data", panel_data, 8'h00);
      reset = 1'b1;
      cyc(1);
      chk("turn_on_fall", ctl, 8'b0110_0000);

      // address load: event 6 edges after press, applied on the 7th
      switches = 8'h03; btn_addr = 1'b1;
      cyc(6);
      chk("addr_before_event", panel_addr, 4'h0);
      cyc(1);
      chk("addr_loaded", panel_addr, 4'h3);
      btn_addr = 1'b0;
      cyc(8);

      // deposit 0xA5 at address 3
      switches = 8'hA5; btn_dep = 1'b1;
      cyc(6);
      chk("dep_idle_before", ctl, 8'b0110_0000);
      we_lo = 0;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         if (!WE) we_lo++;
         chk("dep_ctl", ctl, dep_tab[k]);
         chk("dep_addr", panel_addr, (k == 5) ? 4'h4 : 4'h3);
         chk("dep_data", panel_data, 8'hA5);
         switches = 8'hFF;
      end
      chk("dep_we_pulse", we_lo, 2);
      btn_dep = 1'b0;
      cyc(8);

      // bounce: 2-cycle toggles are rejected, final level produces one deposit
      switches = 8'h5A; cs_lo = 0;
      for (int i = 0; i < 10; i++) begin
         btn_dep = ~btn_dep;
         repeat (2) begin
            @(negedge clk);
            if (!CS) cs_lo++;
         end
      end
      btn_dep = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cyc(1);
         if (!CS) cs_lo++;
         if (k == 6) chk("bounce_cs_k6", CS, 1'b1);
         if (k == 7) chk("bounce_cs_k7", CS, 1'b0);
      end
      chk("bounce_one_dep", cs_lo, 4);
      chk("bounce_addr", panel_addr, 4'h5);
      chk("bounce_data", panel_data, 8'h5A);
      btn_dep = 1'b0;
      cyc(8);

      // wrap: deposit at address 15
      switches = 8'h0F; btn_addr = 1'b1;
      cyc(7);
      btn_addr = 1'b0;
      chk("wrap_addr15", panel_addr, 4'hF);
      cyc(8);
      switches = 8'h3C; btn_dep = 1'b1;
      cyc(12);
      chk("wrap_addr0", panel_addr, 4'h0);
      chk("wrap_data", panel_data, 8'h3C);
      btn_dep = 1'b0;
      cyc(8);

      // asynchronous reset during WRITE
      switches = 8'h77; btn_dep = 1'b1;
      cyc(8);
      chk("abort_in_write", ctl, 8'b1001_0001);
      reset = 1'b0; btn_dep = 1'b0;
      #1;
      chk("abort_ctl", ctl, 8'b0110_1000);
      chk("abort_data", panel_data, 8'h00);
      cyc(1);
      reset = 1'b1;
      cs_lo = 0;
      for (int k = 0; k < 12; k++) begin
         cyc(1);
         if (!CS) cs_lo++;
      end
      chk("abort_no_write", cs_lo, 0);

      // run sequence
      btn_run = 1'b1;
      cyc(6);
      chk("run_before", ctl, 8'b0110_0000);
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk("run_ctl", ctl, run_tab[k]);
      end
      btn_run = 1'b0;

      // deposit ignored while running
      cs_lo = 0; btn_dep = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc(1);
         if (!CS) cs_lo++;
      end
      chk("run_dep_ignored", cs_lo, 0);
      chk("run_still", ctl, 8'b0110_0010);
      chk("run_addr_kept", panel_addr, 4'h0);
      btn_dep = 1'b0;
      cyc(8);

      // halt
      btn_halt = 1'b1;
      cyc(6);
      chk("halt_before", status, 1'b1);
      cyc(1);
      chk("halt_after", ctl, 8'b0110_0000);
      btn_halt = 1'b0;
      cyc(8);

      // single step (no effect when the step option is absent)
      btn_step = 1'b1; stat_hi = 0;
      for (int k = 1; k <= 14; k++) begin
         cyc(1);
         if (status) stat_hi++;
         if (k == 10) start_FETCH = 1'b1;
         if (k == 11) start_FETCH = 1'b0;
      end
      chk("step_status_cycles", stat_hi, STEP_EXP);
      chk("step_end_ctl", ctl, 8'b0110_0000);
      btn_step = 1'b0;
      cyc(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
